branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 3, log2 of BTB entry count (8 entries).
REQ-002 SHALL have parameter CTR_ALLOC, default 2'b10, counter value written on allocation (weakly taken).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port fetch_pc  input  16  PC of instruction being fetched.
REQ-006 SHALL have port pred_taken  output  1  prediction for fetch_pc, combinational.
REQ-007 SHALL have port pred_target  output  16  predicted next PC, combinational.
REQ-008 SHALL have port res_valid  input  1  one branch (opcode 1100 B or 1101 BR) resolved this cycle.
REQ-009 SHALL have port res_pc  input  16  PC of the resolved branch.
REQ-010 SHALL have port res_taken  input  1  actual branch decision.
REQ-011 SHALL have port res_target  input  16  actual taken target (PC+2+offset*2, or rs for BR).
REQ-012 SHALL have port res_fallthru  input  16  PC+2 of the resolved branch.
REQ-013 SHALL have port res_pred_taken  input  1  prediction that was used for this branch.
REQ-014 SHALL have port res_pred_target  input  16  predicted next PC that was used.
REQ-015 SHALL have port mispredict  output  1  registered redirect strobe.
REQ-016 SHALL have port redirect_pc  output  16  registered correct next PC.
REQ-017 SHALL have port br_count  output  16  resolved-branch counter.
REQ-018 SHALL have port mp_count  output  16  misprediction counter.

Function
REQ-019 Each entry SHALL hold valid, tag = pc[15:IDX_W+1], target[15:0], 2-bit saturating counter; index = pc[IDX_W:1]; pc[0] ignored.
REQ-020 Lookup: hit = valid and tag match; pred_taken = hit and ctr[1]; pred_target = entry target when pred_taken, else fetch_pc+2 (16-bit wrap, 16'hFFFE+2 = 16'h0000).
REQ-021 Update on res_valid, hit on res_pc: ctr increments if res_taken (saturate 3), decrements if not (saturate 0); target overwritten with res_target when res_taken.
REQ-022 Update on res_valid, miss, res_taken: allocate/replace entry: valid=1, tag, target=res_target, ctr=CTR_ALLOC.
REQ-023 Update on res_valid, miss, not taken: no BTB write.
REQ-024 Table writes SHALL take effect at the clock edge; a same-cycle lookup of the index being updated returns pre-update contents.
REQ-025 Correct next PC = res_taken ? res_target : res_fallthru; mispredict condition = res_valid and (correct next PC != res_pred_target).
REQ-026 mispredict and redirect_pc SHALL be registered: asserted exactly one cycle after the resolving cycle, for one cycle; redirect_pc holds last value when mispredict is low.
REQ-027 Direction-correct but target-wrong (BR with changed rs) SHALL count as mispredict.
REQ-028 br_count increments on every res_valid; mp_count increments on every mispredict condition; both saturate at 16'hFFFF.
REQ-029 Back-to-back res_valid every cycle SHALL be supported with no stall; each update sees prior updates.

Reset
REQ-030 While rst high at an edge: all valid bits, counters, targets cleared to 0; mispredict=0, redirect_pc=16'h0000, br_count=0, mp_count=0.
REQ-031 rst SHALL override res_valid in the same cycle (no update, no count).
REQ-032 Reset mid-sequence SHALL discard any pending mispredict; first cycle after reset mispredict=0 and every lookup misses (pred_target=fetch_pc+2).

Verification
REQ-033 After reset, fetch_pc=16'h0010 -> pred_taken=0, pred_target=16'h0012.
REQ-034 res_valid, res_pc=16'h0010, res_taken=1, res_target=16'h0040, res_pred_target=16'h0012 -> next cycle mispredict=1, redirect_pc=16'h0040, mp_count=1; then fetch_pc=16'h0010 -> pred_taken=1, pred_target=16'h0040.
REQ-035 Same PC resolved not-taken twice (correct pred_target supplied) -> ctr 2->1->0, pred_taken=0 after first; one more taken -> ctr=1, still predicts not-taken.
REQ-036 Alias: allocate 16'h0010 then taken branch at 16'h0030 (same index, different tag) -> 16'h0010 lookup misses, 16'h0030 hits.
REQ-037 Lookup and update of index 0 in same cycle -> lookup returns old entry; next cycle shows new entry.
REQ-038 Preload br_count to 16'hFFFF via 65535 resolutions, one more res_valid -> stays 16'hFFFF; assert rst with res_valid=1 -> all counters 0, mispredict 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, registered redirect and stats.
// Ports: clk, rst, fetch_pc/pred_*, res_*, mispredict, redirect_pc, counts.
module branch_predictor #(
  parameter int         IDX_W     = 3,
  parameter logic [1:0] CTR_ALLOC = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_pc,
  output logic        pred_taken,
  output logic [15:0] pred_target,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic        res_taken,
  input  logic [15:0] res_target,
  input  logic [15:0] res_fallthru,
  input  logic        res_pred_taken,
  input  logic [15:0] res_pred_target,
  output logic        mispredict,
  output logic [15:0] redirect_pc,
  output logic [15:0] br_count,
  output logic [15:0] mp_count
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 16 - IDX_W - 1;

  logic             valid  [N];
  logic [TAG_W-1:0] tag    [N];
  logic [15:0]      target [N];
  logic [1:0]       ctr    [N];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic [15:0]      next_pc;
  logic             mp_cond;
  logic             unused;

  assign unused = res_pred_taken;

  assign f_idx = fetch_pc[IDX_W:1];
  assign f_tag = fetch_pc[15:IDX_W+1];
  assign f_hit = valid[f_idx] && (tag[f_idx] == f_tag);

  assign pred_taken  = f_hit && ctr[f_idx][1];
  assign pred_target = pred_taken ? target[f_idx]
                                  : fetch_pc + 16'd2;

  assign r_idx = res_pc[IDX_W:1];
  assign r_tag = res_pc[15:IDX_W+1];
  assign r_hit = valid[r_idx] && (tag[r_idx] == r_tag);

  assign next_pc = res_taken ? res_target : res_fallthru;
  assign mp_cond = res_valid && (next_pc != res_pred_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= '0;
      end
    end else if (res_valid) begin
      unique case (1'b1)
        r_hit: begin
          if (res_taken) begin
            target[r_idx] <= res_target;
            if (ctr[r_idx] != 2'd3)
              ctr[r_idx] <= ctr[r_idx] + 2'd1;
          end else if (ctr[r_idx] != 2'd0) begin
            ctr[r_idx] <= ctr[r_idx] - 2'd1;
          end
        end
        !r_hit && res_taken: begin
          valid[r_idx]  <= 1'b1;
          tag[r_idx]    <= r_tag;
          target[r_idx] <= res_target;
          ctr[r_idx]    <= CTR_ALLOC;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      br_count    <= '0;
      mp_count    <= '0;
    end else begin
      mispredict <= mp_cond;
      if (mp_cond)
        redirect_pc <= next_pc;
      if (res_valid && br_count != 16'hFFFF)
        br_count <= br_count + 16'd1;
      if (mp_cond && mp_count != 16'hFFFF)
        mp_count <= mp_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor.
// Drives lookups and resolutions, checks against hand-computed values.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        res_valid;
  logic [15:0] res_pc;
  logic        res_taken;
  logic [15:0] res_target;
  logic [15:0] res_fallthru;
  logic        res_pred_taken;
  logic [15:0] res_pred_target;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .fetch_pc(fetch_pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .res_valid(res_valid),
    .res_pc(res_pc),
    .res_taken(res_taken),
    .res_target(res_target),
    .res_fallthru(res_fallthru),
    .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target),
    .mispredict(mispredict),
    .redirect_pc(redirect_pc),
    .br_count(br_count),
    .mp_count(mp_count)
  );

  task automatic check(input string t,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", t, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input logic [15:0] pc,
                     input logic tk,
                     input logic [15:0] tgt,
                     input logic ptk,
                     input logic [15:0] ptgt);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_taken       = tk;
    res_target      = tgt;
    res_fallthru    = pc + 16'd2;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  task automatic idle();
    res_valid = 1'b0;
  endtask

  task automatic look(input string t,
                      input logic [15:0] pc,
                      input logic tk,
                      input logic [15:0] tgt);
    fetch_pc = pc;
    #1;
    check({t, "_tk"}, {15'd0, pred_taken}, {15'd0, tk});
    check({t, "_tgt"}, pred_target, tgt);
  endtask

  task automatic regs(input string t,
                      input logic mp,
                      input logic [15:0] rd,
                      input logic [15:0] bc,
                      input logic [15:0] mc);
    check({t, "_mp"}, {15'd0, mispredict}, {15'd0, mp});
    check({t, "_rd"}, redirect_pc, rd);
    check({t, "_bc"}, br_count, bc);
    check({t, "_mc"}, mp_count, mc);
  endtask

  initial begin
    rst = 1'b1;
    fetch_pc = 16'h0010;
    idle();
    res(16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    res_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    look("rst_look", 16'h0010, 1'b0, 16'h0012);
    regs("rst", 1'b0, 16'h0000, 16'd0, 16'd0);

    // allocate; same-cycle lookup of index 0 sees old entry
    res(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0012);
    look("same_cyc", 16'h0010, 1'b0, 16'h0012);
    step();
    idle();
    regs("alloc", 1'b1, 16'h0040, 16'd1, 16'd1);
    look("alloc_look", 16'h0010, 1'b1, 16'h0040);
    step();
    regs("mp_pulse", 1'b0, 16'h0040, 16'd1, 16'd1);

    // counter walk 2->1->0->1->2
    res(16'h0010, 1'b0, 16'h0040, 1'b1, 16'h0040);
    step();
    idle();
    regs("nt1", 1'b1, 16'h0012, 16'd2, 16'd2);
    look("nt1_look", 16'h0010, 1'b0, 16'h0012);
    res(16'h0010, 1'b0, 16'h0040, 1'b0, 16'h0012);
    step();
    idle();
    regs("nt2", 1'b0, 16'h0012, 16'd3, 16'd2);
    res(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0012);
    step();
    idle();
    regs("t1", 1'b1, 16'h0040, 16'd4, 16'd3);
    look("t1_look", 16'h0010, 1'b0, 16'h0012);
    res(16'h0010, 1'b1, 16'h0050, 1'b0, 16'h0012);
    step();
    idle();
    look("t2_look", 16'h0010, 1'b1, 16'h0050);

    // alias at same index, different tag
    res(16'h0030, 1'b1, 16'h0080, 1'b0, 16'h0032);
    step();
    idle();
    look("alias_old", 16'h0010, 1'b0, 16'h0012);
    look("alias_new", 16'h0030, 1'b1, 16'h0080);

    // direction right, target wrong
    res(16'h0030, 1'b1, 16'h0090, 1'b1, 16'h0080);
    step();
    idle();
    regs("br_tgt", 1'b1, 16'h0090, 16'd7, 16'd6);
    res(16'h0030, 1'b1, 16'h0090, 1'b1, 16'h0090);
    step();
    idle();
    regs("br_ok", 1'b0, 16'h0090, 16'd8, 16'd6);
    // ctr saturated at 3, one not-taken leaves it predicting taken
    res(16'h0030, 1'b0, 16'h0090, 1'b1, 16'h0090);
    step();
    idle();
    look("sat3", 16'h0030, 1'b1, 16'h0090);

    look("wrap", 16'hFFFE, 1'b0, 16'h0000);

    // back-to-back updates
    res(16'h0002, 1'b1, 16'h0100, 1'b0, 16'h0004);
    step();
    check("b2b_a_rd", redirect_pc, 16'h0100);
    res(16'h0002, 1'b1, 16'h0200, 1'b0, 16'h0004);
    step();
    check("b2b_b_rd", redirect_pc, 16'h0200);
    look("b2b_look", 16'h0002, 1'b1, 16'h0200);
    res(16'h0002, 1'b0, 16'h0200, 1'b1, 16'h0200);
    step();
    check("b2b_c_rd", redirect_pc, 16'h0004);
    res(16'h0002, 1'b0, 16'h0200, 1'b1, 16'h0004);
    step();
    idle();
    regs("b2b_d", 1'b0, 16'h0004, 16'd13, 16'd10);
    look("b2b_d_look", 16'h0002, 1'b0, 16'h0004);

    // reset discards pending mispredict and overrides res_valid
    res(16'h0002, 1'b1, 16'h0300, 1'b0, 16'h0004);
    step();
    check("pre_rst_mp", {15'd0, mispredict}, 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    regs("mid_rst", 1'b0, 16'h0000, 16'd0, 16'd0);
    look("mid_rst_look", 16'h0002, 1'b0, 16'h0004);

    // counter saturation, every resolution mispredicts
    res(16'h0004, 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < 65535; i++) step();
    regs("sat_ffff", 1'b1, 16'h0006, 16'hFFFF, 16'hFFFF);
    step();
    regs("sat_hold", 1'b1, 16'h0006, 16'hFFFF, 16'hFFFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    regs("fin_rst", 1'b0, 16'h0000, 16'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
